id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register of the MIPS pipeline.
- Captures, on each clock edge:
  - the 32-bit extended immediate from the decode-stage sign-extension unit;
  - both register-file read values;
  - the register indices;
  - the decoded control word.
- Contains load-use hazard detection. On a hazard it inserts a one-cycle bubble and requests a PC and IF/ID stall.
- Also honours an external hold and a branch/jump flush.

Parameters:
- CTRL_W, 16, width of the decoded control word passed to EX/MEM/WB.
- DATA_W, 32, datapath width.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Valid_in  input  1  decode stage holds a real instruction.
- ImmExt_in  input  DATA_W  extended immediate from the sign-extension unit.
- RegData1_in  input  DATA_W  register-file read port 1.
- RegData2_in  input  DATA_W  register-file read port 2.
- Rs_in  input  5  source register index.
- Rt_in  input  5  second source / load destination index.
- Rd_in  input  5  R-type destination index.
- UsesRt_in  input  1  the instruction in decode reads Rt as a source.
- MemRead_in  input  1  the instruction in decode is a load.
- Ctrl_in  input  CTRL_W  remaining decoded control bits.
- Flush  input  1  branch/jump taken; kill the decode-stage instruction.
- Stall_ext  input  1  a downstream stage requests a hold.
- ImmExt_out  output  DATA_W  registered immediate.
- RegData1_out  output  DATA_W  registered read data 1.
- RegData2_out  output  DATA_W  registered read data 2.
- Rs_out  output  5  registered index.
- Rt_out  output  5  registered index.
- Rd_out  output  5  registered index.
- MemRead_out  output  1  registered load flag.
- Ctrl_out  output  CTRL_W  registered control bits.
- Valid_out  output  1  EX stage holds a real instruction.
- LoadUseStall  output  1  combinational; freezes the PC and IF/ID.

Behaviour:
- Reset:
  - Rst_n low clears every registered output to 0 immediately, independent of Clk.
  - Leaving reset, the block is idle: Valid_out=0, so LoadUseStall=0.
  - Reset asserted mid-operation discards the held instruction; no partial state survives.
- Hazard detect (combinational), LoadUseStall = 1 only when all of the following hold:
  - Valid_out=1;
  - MemRead_out=1;
  - Rt_out != 0;
  - Valid_in=1;
  - Rt_out==Rs_in, or (UsesRt_in=1 and Rt_out==Rt_in).
- Per rising edge, first matching rule wins:
  1. Flush=1: load a bubble. Valid_out=0, MemRead_out=0, Ctrl_out=0; data and index fields are don't-care and are cleared to 0. Flush overrides Stall_ext and LoadUseStall.
  2. Stall_ext=1: hold every output unchanged. LoadUseStall may stay asserted; that is correct because upstream is also frozen.
  3. LoadUseStall=1: load a bubble, same as rule 1.
  4. Otherwise: capture all inputs.
     - Valid_out <= Valid_in.
     - When Valid_in=0, MemRead_out and Ctrl_out are forced to 0 so that garbage control never reaches EX.
- Latency: one cycle from the decode inputs to the outputs.
- A load-use hazard produces exactly one bubble. After the bubble MemRead_out=0, so LoadUseStall drops. The dependent instruction, held in IF/ID, is then captured on the next edge.
- Register $0: a load to $0 never stalls.
- Back-to-back loads where the second load uses the first's result: one bubble, then the second load is captured normally.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - Adds output BubbleCount, 32 bits, reset to 0.
  - It increments on every edge where rule 1 or rule 3 loads a bubble. An edge where Valid_in=0 passes through does not count.
  - The count saturates at 0xFFFFFFFF.
  - Adds input BubbleCountClr, 1 bit, a synchronous clear that takes priority over increment.
- Not defined: neither port exists, and no counter logic is present.

Test Plan:
- Reset and normal capture:
  - Stimulus: Rst_n low mid-cycle, then release; apply Valid_in=1, ImmExt_in=0xFFFF8000, RegData1_in=5, Rs_in=3, Ctrl_in=0x00A5.
  - Response: all outputs are 0 during reset. After one edge, ImmExt_out=0xFFFF8000, Ctrl_out=0x00A5, Valid_out=1.
- Load-use hazard:
  - Stimulus: the EX stage holds a load with Rt_out=8; the decode stage has Rs_in=8.
  - Response: LoadUseStall=1. The next edge gives Valid_out=0 and Ctrl_out=0, then LoadUseStall=0. The following edge captures the dependent instruction.
- Rt-use gating and $0:
  - Stimulus: a load with Rt_out=8 in EX, decode Rt_in=8 with UsesRt_in=0.
  - Response: LoadUseStall=0.
  - Stimulus: a load with Rt_out=0 in EX, decode Rs_in=0.
  - Response: LoadUseStall=0.
- Flush priority:
  - Stimulus: Flush=1 together with Stall_ext=1 and a pending hazard.
  - Response: the next edge gives Valid_out=0 and MemRead_out=0.
- External hold:
  - Stimulus: Stall_ext=1 for 3 cycles with changing inputs.
  - Response: all outputs stay equal to their pre-stall values. Capture resumes on the first edge after Stall_ext returns to 0.
- ID_EX_BUBBLE_CNT_EN:
  - Stimulus: two load-use hazards and one flush, then BubbleCountClr=1.
  - Response: BubbleCount=3, then 0 on the next edge.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ============================================================================
// Module   : id_ex_stage_reg
// Summary  : MIPS ID/EX pipeline register with load-use hazard detection,
//            external hold and branch/jump flush. Optional macro
//            ID_EX_BUBBLE_CNT_EN adds a saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Valid_in,
  input  logic [DATA_W-1:0] ImmExt_in,
  input  logic [DATA_W-1:0] RegData1_in,
  input  logic [DATA_W-1:0] RegData2_in,
  input  logic [4:0]        Rs_in,
  input  logic [4:0]        Rt_in,
  input  logic [4:0]        Rd_in,
  input  logic              UsesRt_in,
  input  logic              MemRead_in,
  input  logic [CTRL_W-1:0] Ctrl_in,
  input  logic              Flush,
  input  logic              Stall_ext,
  output logic [DATA_W-1:0] ImmExt_out,
  output logic [DATA_W-1:0] RegData1_out,
  output logic [DATA_W-1:0] RegData2_out,
  output logic [4:0]        Rs_out,
  output logic [4:0]        Rt_out,
  output logic [4:0]        Rd_out,
  output logic              MemRead_out,
  output logic [CTRL_W-1:0] Ctrl_out,
  output logic              Valid_out,
`ifdef ID_EX_BUBBLE_CNT_EN
  input  logic              BubbleCountClr,
  output logic [31:0]       BubbleCount,
`endif
  output logic              LoadUseStall
);

  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        rd_q, rd_d;
  logic              memrd_q, memrd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              w_bubble;

  // A load in EX whose destination is read by the instruction in decode.
  assign LoadUseStall = valid_q && memrd_q && (rt_q != 5'd0) && Valid_in &&
                        ((rt_q == Rs_in) || (UsesRt_in && (rt_q == Rt_in)));

  always_comb begin
    imm_d    = imm_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    memrd_d  = memrd_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    w_bubble = 1'b0;
    if (Flush) begin
      w_bubble = 1'b1;
    end else if (!Stall_ext) begin
      if (LoadUseStall) begin
        w_bubble = 1'b1;
      end else begin
        imm_d   = ImmExt_in;
        rd1_d   = RegData1_in;
        rd2_d   = RegData2_in;
        rs_d    = Rs_in;
        rt_d    = Rt_in;
        rd_d    = Rd_in;
        valid_d = Valid_in;
        memrd_d = Valid_in ? MemRead_in : 1'b0;
        ctrl_d  = Valid_in ? Ctrl_in : '0;
      end
    end
    if (w_bubble) begin
      imm_d   = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      memrd_d = 1'b0;
      ctrl_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      imm_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      memrd_q <= 1'b0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      imm_q   <= imm_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      memrd_q <= memrd_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ImmExt_out   = imm_q;
  assign RegData1_out = rd1_q;
  assign RegData2_out = rd2_q;
  assign Rs_out       = rs_q;
  assign Rt_out       = rt_q;
  assign Rd_out       = rd_q;
  assign MemRead_out  = memrd_q;
  assign Ctrl_out     = ctrl_q;
  assign Valid_out    = valid_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bcnt_q, bcnt_d;

  // Clear wins over increment; the count sticks at all-ones.
  always_comb begin
    bcnt_d = bcnt_q;
    if (BubbleCountClr) begin
      bcnt_d = '0;
    end else if (w_bubble && (bcnt_q != 32'hFFFF_FFFF)) begin
      bcnt_d = bcnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign BubbleCount = bcnt_q;
`endif

endmodule

`default_nettype wire
